// File: rtl/debounce_pkg.sv
// Shared types and default constants for the multi-channel button debouncer.
// The repeat FSM enum is only referenced when DEBOUNCE_REPEAT_EN is defined.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;
  localparam int SYNC_STAGES_DEFAULT  = 2;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: synchroniser, stability filter, press/release pulses.
// Define DEBOUNCE_REPEAT_EN to add the hold/auto-repeat state machine.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat,
  output logic press_nxt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   stable_d;

  // Reset loads the released pin level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign pressed = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (pressed == stable_q) begin
      cnt_q    <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_q <= pressed;
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // Pulses land one cycle after the level change.
  assign press_nxt = stable_q & ~stable_d;
  assign btn_level = stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d    <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      stable_d    <= stable_q;
      btn_press   <= press_nxt;
      btn_release <= ~stable_q & stable_d;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HCNT_W  = $clog2(RPT_MAX + 1);

  rpt_state_e        state_q, state_nxt;
  logic [HCNT_W-1:0] hcnt_q, hcnt_nxt;
  logic              rpt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      btn_repeat <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      hcnt_q     <= hcnt_nxt;
      btn_repeat <= rpt_nxt;
    end
  end

  // One counter times the initial hold and then each repeat period.
  always_comb begin
    state_nxt = state_q;
    hcnt_nxt  = '0;
    rpt_nxt   = 1'b0;
    if (!stable_q) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: if (press_nxt) state_nxt = HOLD;
        HOLD: begin
          if (hcnt_q == HCNT_W'(HOLD_CYCLES - 1)) begin
            state_nxt = REPEAT;
            rpt_nxt   = 1'b1;
          end else begin
            hcnt_nxt  = hcnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (hcnt_q == HCNT_W'(REPEAT_CYCLES - 1)) rpt_nxt  = 1'b1;
          else                                      hcnt_nxt = hcnt_q + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// NUM_CH independent debounced buttons plus a registered any-press flag.
// Auto-repeat is present only when DEBOUNCE_REPEAT_EN is defined.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_repeat,
  output logic              any_press
);

  logic [NUM_CH-1:0] press_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i]),
      .press_nxt   (press_nxt[i])
    );
  end

  // Built from the same next-state terms so it rises with btn_press.
  always_ff @(posedge clk) begin
    if (rst) any_press <= 1'b0;
    else     any_press <= |press_nxt;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random pin noise against a
// timestamp/run-length reference model; a second instance runs ACTIVE_LOW=1.
module tb_debounce_multi;
  localparam int NUM_CH = 4, DEB = 8, SYNC = 2, HOLD = 20, REP = 5;
  localparam int LAT = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0] btn = '0;
  logic [NUM_CH-1:0] lvl, prs, rel, rpt, lvl_n, prs_n, rel_n, rpt_n;
  logic any, any_n;

  int errors = 0, checks = 0, cyc = 0;

  // reference model state
  bit m_stb [NUM_CH];
  int m_run [NUM_CH];
  bit m_rose[NUM_CH];
  bit m_fell[NUM_CH];
  int m_pedge[NUM_CH];
  bit m_hist[NUM_CH][$];
  logic [NUM_CH-1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_rpt = '0;
  int n_prs[NUM_CH], n_rel[NUM_CH], n_rpt[NUM_CH], n_any = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1'b0),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn), .btn_level(lvl), .btn_press(prs),
    .btn_release(rel), .btn_repeat(rpt), .any_press(any)
  );

  debounce_multi #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1'b1),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_n (
    .clk(clk), .rst(rst), .btn_in(~btn), .btn_level(lvl_n), .btn_press(prs_n),
    .btn_release(rel_n), .btn_repeat(rpt_n), .any_press(any_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge: advance the model with the values sampled at the edge, then compare.
  task automatic tick();
    bit s;
    int age;
    @(posedge clk);
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_hist[c].delete();
        for (int k = 0; k < SYNC; k++) m_hist[c].push_back(1'b0);
        m_stb[c] = 0; m_run[c] = 0; m_rose[c] = 0; m_fell[c] = 0; m_pedge[c] = -1;
        e_prs[c] = 0; e_rel[c] = 0; e_rpt[c] = 0;
      end else begin
        s = m_hist[c].pop_front();
        m_hist[c].push_back(btn[c]);
        e_prs[c] = m_rose[c];
        e_rel[c] = m_fell[c];
        if (e_prs[c]) m_pedge[c] = cyc;
        e_rpt[c] = 0;
        age = cyc - m_pedge[c];
`ifdef DEBOUNCE_REPEAT_EN
        if (m_stb[c] && m_pedge[c] >= 0 && age >= HOLD && ((age - HOLD) % REP) == 0) e_rpt[c] = 1;
`endif
        if (!m_stb[c]) m_pedge[c] = -1;
        m_rose[c] = 0; m_fell[c] = 0;
        if (s == m_stb[c]) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_stb[c] = s; m_run[c] = 0; m_rose[c] = s; m_fell[c] = !s;
          end
        end
      end
      e_lvl[c] = m_stb[c];
    end
    #1;
    chk("level",     32'(lvl),   32'(e_lvl));
    chk("press",     32'(prs),   32'(e_prs));
    chk("release",   32'(rel),   32'(e_rel));
    chk("repeat",    32'(rpt),   32'(e_rpt));
    chk("any_press", 32'(any),   32'(|e_prs));
    chk("level_n",   32'(lvl_n), 32'(e_lvl));
    chk("press_n",   32'(prs_n), 32'(e_prs));
    chk("release_n", 32'(rel_n), 32'(e_rel));
    chk("repeat_n",  32'(rpt_n), 32'(e_rpt));
    chk("any_n",     32'(any_n), 32'(|e_prs));
    for (int c = 0; c < NUM_CH; c++) begin
      if (prs[c] === 1'b1) n_prs[c]++;
      if (rel[c] === 1'b1) n_rel[c]++;
      if (rpt[c] === 1'b1) n_rpt[c]++;
    end
    if (any === 1'b1) n_any++;
  endtask

  // Returns edges until btn_press[c] (n) and until btn_level[c] first rose (lv); -1 on timeout.
  task automatic wait_press(input int c, input int max, output int n, output int lv);
    n = -1; lv = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (lv < 0 && lvl[c] === 1'b1) lv = i;
      if (prs[c] === 1'b1) begin n = i; break; end
    end
  endtask

  initial begin
    int n, lv, p0, p3, a0, seen_rel, rafter;
    int r[$];
    int cd[NUM_CH];
    for (int c = 0; c < NUM_CH; c++) begin
      n_prs[c] = 0; n_rel[c] = 0; n_rpt[c] = 0;
    end

    rst = 1'b1; btn = '0;
    repeat (3) tick();
    chk("rst_level", 32'(lvl), 0);
    chk("rst_press", 32'(prs), 0);
    chk("rst_any",   32'(any), 0);
    rst = 1'b0;
    repeat (5) tick();

    // clean step on channel 0
    btn[0] = 1'b1;
    wait_press(0, 30, n, lv);
    chk("t1_latency", n, LAT);
    chk("t1_level_lead", lv, LAT - 1);
    chk("t1_others", 32'(prs[3:1]), 0);
    btn[0] = 1'b0;
    repeat (20) tick();

    // bounce on channel 1: 3 high / 2 low for 40 cycles, then hold
    p0 = n_prs[1];
    for (int k = 0; k < 40; k++) begin
      btn[1] = ((k % 5) < 3);
      tick();
    end
    btn[1] = 1'b1;
    wait_press(1, 30, n, lv);
    chk("t2_latency", n, LAT);
    chk("t2_single_press", n_prs[1] - p0, 1);
    btn[1] = 1'b0;
    repeat (20) tick();

    // glitch reject on channel 2, then a just-long-enough pulse
    p0 = n_prs[2]; a0 = n_rel[2];
    btn[2] = 1'b1; repeat (DEB - 1) tick();
    btn[2] = 1'b0; repeat (20) tick();
    chk("t3_glitch_press", n_prs[2] - p0, 0);
    chk("t3_glitch_level", 32'(lvl[2]), 0);
    btn[2] = 1'b1; repeat (DEB) tick();
    btn[2] = 1'b0; repeat (25) tick();
    chk("t3_pulse_press", n_prs[2] - p0, 1);
    chk("t3_pulse_release", n_rel[2] - a0, 1);

    // simultaneous press on channels 0 and 3
    p0 = n_prs[0]; p3 = n_prs[3]; a0 = n_any;
    btn[0] = 1'b1; btn[3] = 1'b1;
    wait_press(0, 30, n, lv);
    chk("t4_latency", n, LAT);
    chk("t4_same_cycle", 32'(prs[3]), 1);
    chk("t4_any_with_press", 32'(any), 1);
    repeat (5) tick();
    chk("t4_any_once", n_any - a0, 1);
    chk("t4_ch0_once", n_prs[0] - p0, 1);
    chk("t4_ch3_once", n_prs[3] - p3, 1);
    btn = '0;
    repeat (20) tick();

    // reset in the middle of an accepted transition
    p0 = n_prs[0];
    btn[0] = 1'b1;
    repeat (SYNC + 5) tick();
    rst = 1'b1; tick();
    chk("t5_rst_level", 32'(lvl), 0);
    chk("t5_rst_pulses", 32'({prs, rel, any}), 0);
    rst = 1'b0;
    wait_press(0, 30, n, lv);
    chk("t5_latency", n, LAT);
    chk("t5_single_press", n_prs[0] - p0, 1);

    // hold channel 0 after its press
`ifdef DEBOUNCE_REPEAT_EN
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rpt[0] === 1'b1) r.push_back(i);
    end
    chk("t6_repeat_count", r.size(), 9);
    chk("t6_first", (r.size() > 0) ? r[0] : -1, HOLD);
    chk("t6_second", (r.size() > 1) ? r[1] : -1, HOLD + REP);
    chk("t6_third", (r.size() > 2) ? r[2] : -1, HOLD + 2 * REP);
`else
    p0 = n_rpt[0];
    repeat (60) tick();
    chk("t6_no_repeat", n_rpt[0] - p0, 0);
`endif
    btn[0] = 1'b0;
    seen_rel = 0; rafter = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (seen_rel != 0 && rpt[0] === 1'b1) rafter++;
      if (rel[0] === 1'b1) seen_rel = 1;
    end
    chk("t6_release_seen", seen_rel, 1);
    chk("t6_repeat_stops", rafter, 0);

    // random pin noise with occasional reset
    for (int c = 0; c < NUM_CH; c++) cd[c] = 1;
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cd[c]--;
        if (cd[c] == 0) begin
          btn[c] = ~btn[c];
          cd[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(10, 70)) : int'($urandom_range(1, 9));
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
